// File: rtl/weight_fetch_sequencer_pkg.sv
// Shared definitions for the weight fetch sequencer.
//   fetch_state_t : controller state encoding (IDLE/FETCH/DRAIN)
//   FIFO_DEPTH    : entries in the read-return skid FIFO
package weight_fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } fetch_state_t;

    localparam int FIFO_DEPTH       = 2;
    localparam int FIFO_COUNT_WIDTH = $clog2(FIFO_DEPTH + 1);

endpackage

// File: rtl/weight_fetch_sequencer_skid_fifo.sv
// Two-entry FIFO holding {last, data} for rows returned by the weight memory.
// Ports:
//   clk, rst         clock, asynchronous active-low reset
//   push, push_data, push_last   write one entry
//   pop              remove the head entry
//   flush            synchronous clear (wins over push/pop)
//   count            current occupancy
//   head_data, head_last         head entry contents
module weight_skid_fifo
    import weight_fetch_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        push,
    input  logic [DATA_WIDTH-1:0]       push_data,
    input  logic                        push_last,
    input  logic                        pop,
    input  logic                        flush,
    output logic [FIFO_COUNT_WIDTH-1:0] count,
    output logic [DATA_WIDTH-1:0]       head_data,
    output logic                        head_last
);

    logic [DATA_WIDTH:0] entry_q [FIFO_DEPTH];
    // Single-bit pointers are enough because the FIFO is exactly two deep.
    logic                rd_ptr_q;
    logic                wr_ptr_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                entry_q[i] <= '0;
            end
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count    <= '0;
        end else if (flush) begin
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            count    <= '0;
        end else begin
            // Push+pop while full writes the slot being vacated this cycle.
            if (push) begin
                entry_q[wr_ptr_q] <= {push_last, push_data};
                wr_ptr_q          <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count <= count + {{(FIFO_COUNT_WIDTH-1){1'b0}}, push}
                           - {{(FIFO_COUNT_WIDTH-1){1'b0}}, pop};
        end
    end

    assign head_data = entry_q[rd_ptr_q][DATA_WIDTH-1:0];
    assign head_last = entry_q[rd_ptr_q][DATA_WIDTH];

endmodule

// File: rtl/weight_fetch_sequencer.sv
// Read-side sequencer for the weight memory: walks a programmed row range,
// absorbs the 1-cycle read latency and streams rows to the PE array.
// Ports:
//   clk, rst                    clock, asynchronous active-low reset
//   start, start_address, num_rows   fetch request (sampled in IDLE)
//   abort                       synchronous flush back to IDLE
//   global_power_down           blocks new reads while high
//   busy, done                  status; done pulses once per fetch/abort
//   weight_control_*            memory read port (never writes)
//   weight_data_out             memory read data, 1 cycle after chip select
//   out_valid/out_ready/out_data/out_last   row stream
//
// state | meaning
// IDLE  | waiting for start
// FETCH | issuing reads while rows remain
// DRAIN | all reads issued, emptying in-flight read and FIFO
module weight_fetch_sequencer
    import weight_fetch_sequencer_pkg::*;
#(
    parameter  int WEIGHT_WORD_BIT_WIDTH = 64,
    parameter  int WEIGHT_ROWS           = 32,
    localparam int WEIGHT_ADDRESS_WIDTH  = $clog2(WEIGHT_ROWS),
    localparam int COUNT_WIDTH           = $clog2(WEIGHT_ROWS + 1)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic [WEIGHT_ADDRESS_WIDTH-1:0]  start_address,
    input  logic [COUNT_WIDTH-1:0]           num_rows,
    input  logic                             abort,
    input  logic                             global_power_down,
    output logic                             busy,
    output logic                             done,
    output logic                             weight_control_chip_select,
    output logic                             weight_control_write_enable,
    output logic [WEIGHT_ADDRESS_WIDTH-1:0]  weight_control_address,
    input  logic [WEIGHT_WORD_BIT_WIDTH-1:0] weight_data_out,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [WEIGHT_WORD_BIT_WIDTH-1:0] out_data,
    output logic                             out_last
);

    fetch_state_t                     state_q, state_d;
    logic [WEIGHT_ADDRESS_WIDTH-1:0]  rd_addr_q, rd_addr_d;
    logic [COUNT_WIDTH-1:0]           remaining_q, remaining_d;
    logic                             in_flight_q;
    logic                             in_flight_last_q;
    logic                             done_q, done_d;

    logic [FIFO_COUNT_WIDTH-1:0]      fifo_count;
    logic [FIFO_COUNT_WIDTH-1:0]      fifo_count_next;
    logic [WEIGHT_WORD_BIT_WIDTH-1:0] head_data;
    logic                             head_last;
    logic                             fifo_empty;
    logic                             fifo_push;
    logic                             fifo_pop;
    logic                             beat;
    logic                             issue;
    logic                             drained;
    logic [2:0]                       occupancy;

    assign fifo_empty = (fifo_count == '0);

    // With the FIFO empty the returning word is presented directly, so the
    // first row is visible in the same cycle it comes back from memory.
    assign out_valid = !fifo_empty || in_flight_q;
    assign out_data  = !fifo_empty ? head_data
                     : (in_flight_q ? weight_data_out : '0);
    assign out_last  = !fifo_empty ? head_last : (in_flight_q && in_flight_last_q);

    assign beat      = out_valid && out_ready;
    assign fifo_pop  = beat && !fifo_empty;
    assign fifo_push = in_flight_q && !abort && !(fifo_empty && beat);

    // Credit: buffered rows plus the read in flight, minus this cycle's beat.
    assign occupancy = {1'b0, fifo_count} + {2'b00, in_flight_q} - {2'b00, beat};

    assign issue = (state_q == FETCH) && (remaining_q != '0) && !global_power_down
                   && !abort && (occupancy < 3'd2);

    assign fifo_count_next = fifo_count
                             + {{(FIFO_COUNT_WIDTH-1){1'b0}}, fifo_push}
                             - {{(FIFO_COUNT_WIDTH-1){1'b0}}, fifo_pop};
    assign drained = (fifo_count_next == '0);

    assign weight_control_chip_select  = issue;
    assign weight_control_address      = issue ? rd_addr_q : '0;
    assign weight_control_write_enable = 1'b0;

    assign busy = (state_q != IDLE);
    assign done = done_q;

    always_comb begin
        state_d     = state_q;
        rd_addr_d   = rd_addr_q;
        remaining_d = remaining_q;
        done_d      = 1'b0;

        if (issue) begin
            rd_addr_d   = (rd_addr_q == WEIGHT_ADDRESS_WIDTH'(WEIGHT_ROWS - 1))
                          ? '0 : rd_addr_q + 1'b1;
            remaining_d = remaining_q - 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (abort) begin
                    done_d = 1'b1;
                end else if (start) begin
                    if (num_rows != '0) begin
                        state_d     = FETCH;
                        rd_addr_d   = start_address;
                        remaining_d = num_rows;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (abort) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (issue && remaining_q == COUNT_WIDTH'(1)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (abort || drained) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q          <= IDLE;
            rd_addr_q        <= '0;
            remaining_q      <= '0;
            in_flight_q      <= 1'b0;
            in_flight_last_q <= 1'b0;
            done_q           <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_addr_q   <= rd_addr_d;
            remaining_q <= remaining_d;
            in_flight_q <= issue;
            done_q      <= done_d;
            if (issue) begin
                in_flight_last_q <= (remaining_q == COUNT_WIDTH'(1));
            end
        end
    end

    weight_skid_fifo #(
        .DATA_WIDTH (WEIGHT_WORD_BIT_WIDTH)
    ) u_skid_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (weight_data_out),
        .push_last (in_flight_last_q),
        .pop       (fifo_pop),
        .flush     (abort),
        .count     (fifo_count),
        .head_data (head_data),
        .head_last (head_last)
    );

endmodule

// File: tb/tb_weight_fetch_sequencer.sv
// Randomized self-checking bench for weight_fetch_sequencer with a memory
// model and a queue-based reference of the expected row stream.
module tb_weight_fetch_sequencer;

    localparam int ROWS = 32;
    localparam int W    = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic [4:0]    start_address = '0;
    logic [5:0]    num_rows = '0;
    logic          abort = 1'b0;
    logic          global_power_down = 1'b0;
    logic          busy, done;
    logic          weight_control_chip_select;
    logic          weight_control_write_enable;
    logic [4:0]    weight_control_address;
    logic [W-1:0]  weight_data_out = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic          out_last;

    weight_fetch_sequencer #(
        .WEIGHT_WORD_BIT_WIDTH (W),
        .WEIGHT_ROWS           (ROWS)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .start                       (start),
        .start_address               (start_address),
        .num_rows                    (num_rows),
        .abort                       (abort),
        .global_power_down           (global_power_down),
        .busy                        (busy),
        .done                        (done),
        .weight_control_chip_select  (weight_control_chip_select),
        .weight_control_write_enable (weight_control_write_enable),
        .weight_control_address      (weight_control_address),
        .weight_data_out             (weight_data_out),
        .out_valid                   (out_valid),
        .out_ready                   (out_ready),
        .out_data                    (out_data),
        .out_last                    (out_last)
    );

    always #5 clk = ~clk;

    logic [W-1:0] mem [ROWS];

    always @(posedge clk) begin
        if (weight_control_chip_select) begin
            weight_data_out <= mem[weight_control_address];
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    int ready_pct = 100;
    int pd_pct    = 0;
    bit pd_force  = 1'b0;

    always @(posedge clk) begin
        #1;
        out_ready         = ($urandom_range(99) < ready_pct);
        global_power_down = pd_force || ($urandom_range(99) < pd_pct);
    end

    // Reference: the row stream a fetch must produce, in order.
    logic [W:0]   exp_q [$];
    int           exp_addr;
    int           exp_n;
    int           reads_f, beats_f;
    int           cyc = 0;
    int           start_cyc, first_cs_cyc, last_cs_cyc, first_valid_cyc, last_beat_cyc, done_cyc;
    bit           mon_en = 1'b0;
    bit           stall_prev = 1'b0;
    logic [W-1:0] prev_data;
    logic         prev_last;

    always @(negedge clk) begin
        if (mon_en) begin
            cyc++;
            if (start && !busy) start_cyc = cyc;
            if (weight_control_chip_select) begin
                chk("no_read_in_powerdown", global_power_down, 0);
                chk("write_enable_low", weight_control_write_enable, 0);
                chk("read_address", weight_control_address, exp_addr);
                if (reads_f == 0) first_cs_cyc = cyc;
                last_cs_cyc = cyc;
                exp_addr = (exp_addr + 1) % ROWS;
                reads_f++;
                chk("read_count_bound", reads_f <= exp_n, 1);
            end
            if (stall_prev) begin
                chk("stall_valid_held", out_valid, 1);
                chk("stall_data_stable", out_data, prev_data);
                chk("stall_last_stable", out_last, prev_last);
            end
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 1, 0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    chk("beat_data", out_data, e[W-1:0]);
                    chk("beat_last", out_last, e[W]);
                end
                beats_f++;
                last_beat_cyc = cyc;
            end
            if (done) done_cyc = cyc;
            if (abort) exp_q.delete();
            stall_prev = out_valid && !out_ready && !abort;
            prev_data  = out_data;
            prev_last  = out_last;
        end
    end

    task automatic start_fetch(input int sa, input int n);
        @(posedge clk);
        #1;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({(i == n - 1), mem[(sa + i) % ROWS]});
        end
        exp_addr = sa;
        exp_n = n;
        reads_f = 0;
        beats_f = 0;
        first_cs_cyc = -1;
        last_cs_cyc = -1;
        first_valid_cyc = -1;
        last_beat_cyc = -1;
        done_cyc = -1;
        start = 1'b1;
        start_address = 5'(sa);
        num_rows = 6'(n);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        chk("done_seen", seen, 1);
        @(negedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
    endtask

    task automatic finish_fetch(input int n);
        wait_done(600);
        chk("all_rows_delivered", exp_q.size(), 0);
        chk("reads_issued", reads_f, n);
        chk("beats_delivered", beats_f, n);
    endtask

    initial begin
        for (int i = 0; i < ROWS; i++) mem[i] = {$urandom(), $urandom()};

        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_cs", weight_control_chip_select, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_addr", weight_control_address, 0);
        chk("rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        mon_en = 1'b1;

        // Basic fetch with timing checks.
        start_fetch(3, 4);
        finish_fetch(4);
        chk("first_read_latency", first_cs_cyc - start_cyc, 1);
        chk("reads_back_to_back", last_cs_cyc - first_cs_cyc, 3);
        chk("first_valid_latency", first_valid_cyc - start_cyc, 2);
        chk("done_after_last_beat", done_cyc - last_beat_cyc, 1);

        // Address wrap.
        start_fetch(30, 4);
        finish_fetch(4);

        // Stall with consumer not ready.
        @(negedge clk);
        #1;
        ready_pct = 0;
        start_fetch(7, 5);
        repeat (10) @(negedge clk);
        #1;
        chk("reads_before_stall", reads_f, 2);
        ready_pct = 100;
        finish_fetch(5);

        // Power-down window during an 8-row fetch.
        start_fetch(12, 8);
        @(negedge clk);
        #1;
        pd_force = 1'b1;
        repeat (4) @(negedge clk);
        #1;
        pd_force = 1'b0;
        finish_fetch(8);

        // Abort the cycle after the third read.
        start_fetch(20, 8);
        for (int i = 0; i < 50 && reads_f < 3; i++) begin
            @(negedge clk);
            #1;
        end
        chk("third_read_seen", reads_f, 3);
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        #1;
        chk("abort_valid_low", out_valid, 0);
        chk("abort_busy_low", busy, 0);
        chk("abort_done", done, 1);
        start_fetch(9, 2);
        finish_fetch(2);

        // Abort while idle still pulses done.
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        @(negedge clk);
        #1;
        chk("idle_abort_done", done, 1);

        // Zero-row request.
        start_fetch(5, 0);
        @(negedge clk);
        #1;
        chk("zero_rows_done", done, 1);
        chk("zero_rows_busy", busy, 0);
        chk("zero_rows_no_reads", reads_f, 0);

        // Randomized fetches.
        for (int t = 0; t < 10; t++) begin
            int sa, n;
            sa = $urandom_range(ROWS - 1);
            n  = $urandom_range(ROWS);
            @(negedge clk);
            #1;
            ready_pct = $urandom_range(100, 30);
            pd_pct    = $urandom_range(30);
            start_fetch(sa, n);
            finish_fetch(n);
        end
        @(negedge clk);
        #1;
        ready_pct = 100;
        pd_pct = 0;

        // Asynchronous reset in the middle of a fetch.
        start_fetch(0, 8);
        repeat (3) @(posedge clk);
        #3;
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        chk("async_rst_busy", busy, 0);
        chk("async_rst_done", done, 0);
        chk("async_rst_cs", weight_control_chip_select, 0);
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_last", out_last, 0);
        chk("async_rst_addr", weight_control_address, 0);
        chk("async_rst_data", out_data, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        stall_prev = 1'b0;
        mon_en = 1'b1;
        start_fetch(17, 3);
        finish_fetch(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
